mole_hit_judge: RTL
===================

MOLE_HIT_JUDGE -- requirements
Module: mole_hit_judge

Interface
REQ-001 Parameter N_MOLES, default 18: number of mole slots, one per LEDR/SW pair.
REQ-002 Parameter LIFE_CYCLES, default 50000000: clock cycles a raised mole stays up before it escapes; legal range is 2 or more.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 restart  input  1  synchronous clear of all slots and of hit_count; held for one or more cycles.
REQ-006 mole_spawn  input  N_MOLES  one-cycle request per slot to raise a mole; driven by the mole spawner.
REQ-007 sw  input  N_MOLES  debounced switch levels.
REQ-008 mole_up  output  N_MOLES  registered per-slot mole-raised state; drives LEDR.
REQ-009 hit  output  1  registered one-cycle pulse when one or more moles are hit in a cycle.
REQ-010 escaped  output  1  registered one-cycle pulse when one or more moles time out in a cycle.
REQ-011 penalty  output  1  registered one-cycle pulse for a switch toggle on an empty slot (MISS_PENALTY_EN only; otherwise tied 0).
REQ-012 hit_count  output  11  running count of hits, saturating.

Function
REQ-013 Each slot is a two-state FSM, DOWN/UP, with a private lifetime down-counter of width $clog2(LIFE_CYCLES+1).
REQ-014 A toggle on slot i is sw[i] differing from its value registered on the previous cycle; rising and falling changes both count.
REQ-015 DOWN->UP: mole_spawn[i]=1 while in DOWN; the counter loads LIFE_CYCLES; mole_up[i]=1 on the next cycle.
REQ-016 mole_spawn[i] while the slot is in UP is ignored; the counter is not reloaded.
REQ-017 UP->DOWN on hit: a toggle on slot i while in UP; mole_up[i]=0 and hit=1 on the next cycle.
REQ-018 While in UP, the counter decrements by 1 each cycle.
REQ-019 UP->DOWN on escape: the counter equals 1 while in UP with no toggle; mole_up[i]=0 and escaped=1 on the next cycle.
REQ-020 A toggle and an expiry on the same slot in the same cycle count as a hit, not an escape.
REQ-021 hit_count increases by the population count of slots hit in that cycle, saturating at 2047, never wrapping.
REQ-022 hit, escaped and penalty are OR-reductions across slots; several events in one cycle give a single one-cycle pulse.
REQ-023 A spawn arriving in the same cycle a slot leaves UP is ignored; the slot is DOWN on the next cycle.
REQ-024 restart has priority over spawn, toggle and expiry: all slots go to DOWN, counters to 0, hit_count to 0, pulses to 0 on the next cycle.
REQ-025 During the cycle restart is asserted, the switch history register still samples sw, so releasing restart does not produce a false toggle.

Reset
REQ-026 While rst_n=0, asynchronously: mole_up=0, hit=0, escaped=0, penalty=0, hit_count=0, all counters 0, all slots DOWN.
REQ-027 The switch history register clears to 0 with reset, and a primed flag clears to 0.
REQ-028 In the first cycle after rst_n deasserts, sw is sampled with toggle detection suppressed; primed=1 from the second cycle on.
REQ-029 Reset mid-lifetime discards the mole with no escaped pulse.

Configuration
REQ-030 Macro MISS_PENALTY_EN is compiled in or out with a preprocessor define.
REQ-031 With MISS_PENALTY_EN defined, a toggle on a slot in DOWN (after priming, without restart) asserts penalty for one cycle.
REQ-032 With MISS_PENALTY_EN defined, a penalty event decrements hit_count by 1, saturating at 0.
REQ-033 With MISS_PENALTY_EN defined, if a hit and a penalty occur in the same cycle, both apply: net change = hits - 1, clamped to the range 0..2047.
REQ-034 Without MISS_PENALTY_EN, toggles on DOWN slots are ignored, penalty is constant 0, and no penalty logic is synthesized.

Verification
REQ-035 LIFE_CYCLES=4; spawn slot 3 at cycle 0, no toggle -> mole_up[3]=1 for cycles 1-4, escaped=1 and mole_up[3]=0 at cycle 5, hit_count=0.
REQ-036 Spawn slots 0 and 17; toggle both sw bits in the same cycle 2 cycles later -> single hit pulse, both mole_up bits clear, hit_count=2.
REQ-037 LIFE_CYCLES=4; toggle slot 3 in the expiry cycle -> hit=1, escaped=0, hit_count=1.
REQ-038 Preload hit_count to 2047 via hits, then hit once more -> hit_count stays 2047.
REQ-039 sw=all ones held through reset release -> no hit or penalty in the first two cycles; assert restart with mole 5 up -> all mole_up=0 and hit_count=0 next cycle.
REQ-040 With MISS_PENALTY_EN, hit_count=1, toggle empty slot 7 -> penalty pulse, hit_count=0; toggle again -> hit_count stays 0.

Source files
------------

// File: rtl/mole_hit_judge.sv
// Whack-a-mole hit judge: per-slot DOWN/UP mole FSMs with lifetime timers, switch toggle
// detection, hit/escape pulses and a saturating hit counter. Optional MISS_PENALTY_EN build.
module mole_hit_judge #(
    parameter int N_MOLES     = 18,
    parameter int LIFE_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restart,
    input  logic [N_MOLES-1:0] mole_spawn,
    input  logic [N_MOLES-1:0] sw,
    output logic [N_MOLES-1:0] mole_up,
    output logic               hit,
    output logic               escaped,
    output logic               penalty,
    output logic [10:0]        hit_count
);

    localparam int              CW        = $clog2(LIFE_CYCLES + 1);
    localparam logic [CW-1:0]   LIFE_LOAD = CW'(LIFE_CYCLES);
    localparam logic [12:0]     COUNT_MAX = 13'd2047;

    typedef enum logic {
        S_DOWN = 1'b0,
        S_UP   = 1'b1
    } slot_state_t;

    slot_state_t        state_q [N_MOLES];
    slot_state_t        state_d [N_MOLES];
    logic [CW-1:0]      cnt_q   [N_MOLES];
    logic [CW-1:0]      cnt_d   [N_MOLES];
    logic [N_MOLES-1:0] sw_hist_q, sw_hist_d;
    logic               primed_q, primed_d;
    logic               hit_q, hit_d;
    logic               escaped_q, escaped_d;
    logic [10:0]        hit_count_q, hit_count_d;

    logic [N_MOLES-1:0] toggle;
    logic [N_MOLES-1:0] hit_vec;
    logic [N_MOLES-1:0] esc_vec;
    logic [12:0]        hit_sum;
    logic [12:0]        count_sum;

`ifdef MISS_PENALTY_EN
    logic [N_MOLES-1:0] miss_vec;
    logic               penalty_q, penalty_d;
`endif

    // The history register always samples sw (even under restart); only priming gates toggles.
    always_comb begin
        sw_hist_d = sw;
        primed_d  = 1'b1;
        toggle    = primed_q ? (sw ^ sw_hist_q) : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_vec = '0;
        esc_vec = '0;
`ifdef MISS_PENALTY_EN
        miss_vec = '0;
`endif
        for (int i = 0; i < N_MOLES; i++) begin
            if (restart) begin
                state_d[i] = S_DOWN;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    S_UP: begin
                        // A toggle on the expiry cycle wins over the escape.
                        if (toggle[i]) begin
                            state_d[i] = S_DOWN;
                            cnt_d[i]   = '0;
                            hit_vec[i] = 1'b1;
                        end else if (cnt_q[i] == CW'(1)) begin
                            state_d[i] = S_DOWN;
                            cnt_d[i]   = '0;
                            esc_vec[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end
                    end
                    S_DOWN: begin
                        if (mole_spawn[i]) begin
                            state_d[i] = S_UP;
                            cnt_d[i]   = LIFE_LOAD;
                        end
`ifdef MISS_PENALTY_EN
                        else if (toggle[i]) begin
                            miss_vec[i] = 1'b1;
                        end
`endif
                    end
                    default: begin
                        state_d[i] = S_DOWN;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        hit_sum = '0;
        for (int i = 0; i < N_MOLES; i++) begin
            hit_sum = hit_sum + 13'(hit_vec[i]);
        end
        count_sum = 13'(hit_count_q) + hit_sum;
`ifdef MISS_PENALTY_EN
        // Hits and a miss in the same cycle net out before clamping.
        if ((|miss_vec) && (count_sum != 13'd0)) begin
            count_sum = count_sum - 13'd1;
        end
`endif
        if (restart) begin
            hit_count_d = '0;
        end else if (count_sum > COUNT_MAX) begin
            hit_count_d = COUNT_MAX[10:0];
        end else begin
            hit_count_d = count_sum[10:0];
        end
        hit_d     = |hit_vec;
        escaped_d = |esc_vec;
`ifdef MISS_PENALTY_EN
        penalty_d = |miss_vec;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= '{default: S_DOWN};
            cnt_q       <= '{default: '0};
            sw_hist_q   <= '0;
            primed_q    <= 1'b0;
            hit_q       <= 1'b0;
            escaped_q   <= 1'b0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sw_hist_q   <= sw_hist_d;
            primed_q    <= primed_d;
            hit_q       <= hit_d;
            escaped_q   <= escaped_d;
            hit_count_q <= hit_count_d;
        end
    end

`ifdef MISS_PENALTY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            penalty_q <= 1'b0;
        end else begin
            penalty_q <= penalty_d;
        end
    end

    assign penalty = penalty_q;
`else
    assign penalty = 1'b0;
`endif

    always_comb begin
        mole_up = '0;
        for (int i = 0; i < N_MOLES; i++) begin
            mole_up[i] = (state_q[i] == S_UP);
        end
    end

    assign hit       = hit_q;
    assign escaped   = escaped_q;
    assign hit_count = hit_count_q;

endmodule
